// File: rtl/fifo_sync_prog.sv
// -----------------------------------------------------------------------------
// fifo_sync_prog
//   Single-clock FIFO with programmable almost-full / almost-empty thresholds,
//   a fill-level output, synchronous flush and sticky overflow/underflow flags.
//   Two read modes, chosen at elaboration time:
//     FWFT = 0 : standard mode. An accepted read loads the head word into
//                read_data on the same edge.
//     FWFT = 1 : first-word-fall-through. An output register holds the head
//                word; empty is low whenever that register is valid, and read
//                acknowledges the word currently on read_data.
//
// Ports
//   clk          clock, rising edge
//   reset        asynchronous reset, active low
//   flush        synchronous clear of contents and error flags
//   write        write request, write_data is the word to store
//   read         read request (FWFT: acknowledge of head word)
//   read_data    output word
//   af_level     almost-full threshold  (almost_full  = level >= af_level)
//   ae_level     almost-empty threshold (almost_empty = level <= ae_level)
//   level        words currently held, 0..DEPTH (FWFT: includes output reg)
//   empty/full   status
//   overflow     sticky: write attempted while full
//   underflow    sticky: read attempted while empty
// -----------------------------------------------------------------------------
module fifo_sync_prog #(
   parameter  int DATA_WIDTH = 8,
   parameter  int DEPTH      = 256,
   parameter  int FWFT       = 0,
   localparam int AW         = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  write,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  read,
   output logic [DATA_WIDTH-1:0] read_data,
   input  logic [AW:0]           af_level,
   input  logic [AW:0]           ae_level,
   output logic [AW:0]           level,
   output logic                  empty,
   output logic                  full,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow,
   output logic                  underflow
);

   localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic                  out_valid;
   logic                  wr_acc;
   logic                  rd_acc;
   logic                  pop;
   logic [AW:0]           arr_cnt;

   // Status flags are combinational from the registered level so that
   // threshold changes show up in the same cycle.
   assign full         = (level == FULL_LVL);
   assign empty        = (FWFT != 0) ? !out_valid : (level == '0);
   assign almost_full  = (level >= af_level);
   assign almost_empty = (level <= ae_level);

   // A full FIFO never accepts a write, even with a simultaneous read:
   // that keeps the write from landing on the slot being read.
   assign wr_acc = write & ~full;
   assign rd_acc = read & ~empty;

   // Words still sitting in the array (level minus the one already
   // presented in the FWFT output register). In standard mode out_valid
   // stays 0 and this equals level.
   assign arr_cnt = level - {{AW{1'b0}}, out_valid};

   // pop = move the head of the array into read_data.
   //   standard: on every accepted read
   //   FWFT    : whenever the output register is (or is about to become)
   //             free and the array has a word, which gives prefetch on
   //             an idle output and bubble-free back-to-back reads.
   assign pop = (FWFT != 0) ? ((~out_valid | rd_acc) & (arr_cnt != '0))
                            : rd_acc;

   // Storage array: no reset, written only on accepted writes.
   always_ff @(posedge clk) begin
      if (wr_acc && !flush)
         mem[wr_ptr] <= write_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         out_valid <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         read_data <= '0;
      end else if (flush) begin
         // read_data deliberately keeps its last value across a flush.
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         out_valid <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc)
            wr_ptr <= wr_ptr + PTR_ONE;

         // A popped word was written on an earlier edge (arr_cnt counted
         // it), so the array read never races the same-cycle write.
         if (pop) begin
            read_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + PTR_ONE;
         end

         if (FWFT != 0) begin
            if (pop)
               out_valid <= 1'b1;
            else if (rd_acc)
               out_valid <= 1'b0;
         end

         // Simultaneous accepted read and write leave the level unchanged.
         if (wr_acc && !rd_acc)
            level <= level + LVL_ONE;
         else if (rd_acc && !wr_acc)
            level <= level - LVL_ONE;

         if (write && full)
            overflow <= 1'b1;
         if (read && empty)
            underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fifo_sync_prog.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync_prog
//   Drives one standard-mode and one FWFT-mode fifo_sync_prog (DEPTH=8) with
//   the same inputs. Both are compared every cycle against a queue-based
//   reference model; a table of hand-computed vectors and a few directed
//   sequences add independent expectations for the corner cases.
// -----------------------------------------------------------------------------
module tb_fifo_sync_prog;

   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          flush = 1'b0;
   logic          write = 1'b0;
   logic          read  = 1'b0;
   logic [7:0]    write_data = '0;
   logic [AW:0]   af_level = '0;
   logic [AW:0]   ae_level = 4'd1;

   logic [7:0]    rd_s, rd_f;
   logic [AW:0]   lvl_s, lvl_f;
   logic          emp_s, ful_s, af_s, ae_s, ov_s, un_s;
   logic          emp_f, ful_f, af_f, ae_f, ov_f, un_f;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fifo_sync_prog #(.DATA_WIDTH(8), .DEPTH(DEPTH), .FWFT(0)) u_std (
      .clk(clk), .reset(reset), .flush(flush), .write(write),
      .write_data(write_data), .read(read), .read_data(rd_s),
      .af_level(af_level), .ae_level(ae_level), .level(lvl_s),
      .empty(emp_s), .full(ful_s), .almost_full(af_s),
      .almost_empty(ae_s), .overflow(ov_s), .underflow(un_s));

   fifo_sync_prog #(.DATA_WIDTH(8), .DEPTH(DEPTH), .FWFT(1)) u_fw (
      .clk(clk), .reset(reset), .flush(flush), .write(write),
      .write_data(write_data), .read(read), .read_data(rd_f),
      .af_level(af_level), .ae_level(ae_level), .level(lvl_f),
      .empty(emp_f), .full(ful_f), .almost_full(af_f),
      .almost_empty(ae_f), .overflow(ov_f), .underflow(un_f));

   // ---------------- reference model ----------------
   // qs: standard-mode contents. qf: FWFT contents (head first); vf says
   // whether the head of qf has already fallen through to read_data.
   logic [7:0] qs[$];
   logic [7:0] qf[$];
   logic [7:0] rs, rf;
   bit         vf, ovs, uns, ovf, unf;

   task automatic model_reset();
      qs.delete(); qf.delete();
      rs = 8'h00; rf = 8'h00;
      vf = 0; ovs = 0; uns = 0; ovf = 0; unf = 0;
   endtask

   task automatic model_step(input bit w, input logic [7:0] wd, input bit r, input bit fl);
      bit wa, ra;
      int hidden;
      if (fl) begin
         qs.delete(); qf.delete();
         vf = 0; ovs = 0; uns = 0; ovf = 0; unf = 0;
      end else begin
         wa = w && (qs.size() < DEPTH);
         ra = r && (qs.size() > 0);
         if (w && !wa) ovs = 1;
         if (r && !ra) uns = 1;
         if (ra) rs = qs.pop_front();
         if (wa) qs.push_back(wd);

         wa = w && (qf.size() < DEPTH);
         ra = r && vf;
         if (w && !wa) ovf = 1;
         if (r && !ra) unf = 1;
         hidden = qf.size() - (vf ? 1 : 0);
         if (ra) begin
            void'(qf.pop_front());
            vf = (hidden > 0);
         end else if (!vf && hidden > 0) begin
            vf = 1;
         end
         if (vf) rf = qf[0];
         if (wa) qf.push_back(wd);
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   task automatic compare_all();
      chk("std.level",   32'(lvl_s), 32'(qs.size()));
      chk("std.empty",   32'(emp_s), 32'(qs.size() == 0));
      chk("std.full",    32'(ful_s), 32'(qs.size() == DEPTH));
      chk("std.afull",   32'(af_s),  32'(qs.size() >= int'(af_level)));
      chk("std.aempty",  32'(ae_s),  32'(qs.size() <= int'(ae_level)));
      chk("std.ovf",     32'(ov_s),  32'(ovs));
      chk("std.unf",     32'(un_s),  32'(uns));
      chk("std.rdata",   32'(rd_s),  32'(rs));
      chk("fw.level",    32'(lvl_f), 32'(qf.size()));
      chk("fw.empty",    32'(emp_f), 32'(!vf));
      chk("fw.full",     32'(ful_f), 32'(qf.size() == DEPTH));
      chk("fw.afull",    32'(af_f),  32'(qf.size() >= int'(af_level)));
      chk("fw.aempty",   32'(ae_f),  32'(qf.size() <= int'(ae_level)));
      chk("fw.ovf",      32'(ov_f),  32'(ovf));
      chk("fw.unf",      32'(un_f),  32'(unf));
      chk("fw.rdata",    32'(rd_f),  32'(rf));
   endtask

   task automatic step(input bit w, input logic [7:0] wd, input bit r, input bit fl);
      write = w; write_data = wd; read = r; flush = fl;
      @(posedge clk);
      model_step(w, wd, r, fl);
      #1;
      write = 0; read = 0; flush = 0;
      compare_all();
   endtask

   // ---------------- vector table (standard mode, af=6, ae=1) ----------------
   typedef struct {
      bit         w;
      bit         r;
      logic [7:0] wd;
      int         lvl;
      bit         emp, ful, ae, af, ov;
      logic [7:0] rd;
   } vec_t;

   function automatic vec_t mk(bit w, bit r, logic [7:0] wd, int lvl, bit emp,
                               bit ful, bit ae, bit af, bit ov, logic [7:0] rd);
      vec_t v;
      v.w = w; v.r = r; v.wd = wd; v.lvl = lvl; v.emp = emp; v.ful = ful;
      v.ae = ae; v.af = af; v.ov = ov; v.rd = rd;
      return v;
   endfunction

   vec_t tbl [17];

   initial begin
      int wp;

      // 8 writes 0x10..0x17, a rejected 9th write, then 8 reads.
      tbl[0]  = mk(1, 0, 8'h10, 1, 0, 0, 1, 0, 0, 8'h00);
      tbl[1]  = mk(1, 0, 8'h11, 2, 0, 0, 0, 0, 0, 8'h00);
      tbl[2]  = mk(1, 0, 8'h12, 3, 0, 0, 0, 0, 0, 8'h00);
      tbl[3]  = mk(1, 0, 8'h13, 4, 0, 0, 0, 0, 0, 8'h00);
      tbl[4]  = mk(1, 0, 8'h14, 5, 0, 0, 0, 0, 0, 8'h00);
      tbl[5]  = mk(1, 0, 8'h15, 6, 0, 0, 0, 1, 0, 8'h00);
      tbl[6]  = mk(1, 0, 8'h16, 7, 0, 0, 0, 1, 0, 8'h00);
      tbl[7]  = mk(1, 0, 8'h17, 8, 0, 1, 0, 1, 0, 8'h00);
      tbl[8]  = mk(1, 0, 8'h99, 8, 0, 1, 0, 1, 1, 8'h00);
      tbl[9]  = mk(0, 1, 8'h00, 7, 0, 0, 0, 1, 1, 8'h10);
      tbl[10] = mk(0, 1, 8'h00, 6, 0, 0, 0, 1, 1, 8'h11);
      tbl[11] = mk(0, 1, 8'h00, 5, 0, 0, 0, 0, 1, 8'h12);
      tbl[12] = mk(0, 1, 8'h00, 4, 0, 0, 0, 0, 1, 8'h13);
      tbl[13] = mk(0, 1, 8'h00, 3, 0, 0, 0, 0, 1, 8'h14);
      tbl[14] = mk(0, 1, 8'h00, 2, 0, 0, 0, 0, 1, 8'h15);
      tbl[15] = mk(0, 1, 8'h00, 1, 0, 0, 1, 0, 1, 8'h16);
      tbl[16] = mk(0, 1, 8'h00, 0, 1, 0, 1, 0, 1, 8'h17);

      // ---- reset state, af_level = 0 forces almost_full ----
      #2 reset = 1'b0;
      #1;
      model_reset();
      compare_all();
      chk("rst.std.afull_at_af0", 32'(af_s), 32'd1);
      af_level = 4'd6;
      #1;
      compare_all();
      @(negedge clk) reset = 1'b1;

      // ---- table: fill, overflow, drain ----
      for (int i = 0; i < 17; i++) begin
         step(tbl[i].w, tbl[i].wd, tbl[i].r, 1'b0);
         chk($sformatf("tbl[%0d].level", i),  32'(lvl_s), 32'(tbl[i].lvl));
         chk($sformatf("tbl[%0d].empty", i),  32'(emp_s), 32'(tbl[i].emp));
         chk($sformatf("tbl[%0d].full", i),   32'(ful_s), 32'(tbl[i].ful));
         chk($sformatf("tbl[%0d].aempty", i), 32'(ae_s),  32'(tbl[i].ae));
         chk($sformatf("tbl[%0d].afull", i),  32'(af_s),  32'(tbl[i].af));
         chk($sformatf("tbl[%0d].ovf", i),    32'(ov_s),  32'(tbl[i].ov));
         chk($sformatf("tbl[%0d].rdata", i),  32'(rd_s),  32'(tbl[i].rd));
      end

      // ---- simultaneous read+write at level 3 for 20 cycles (wraps) ----
      step(0, 8'h00, 0, 1);
      for (int i = 0; i < 3; i++) step(1, 8'h20 + 8'(i), 0, 0);
      for (int i = 0; i < 20; i++) begin
         step(1, 8'h40 + 8'(i), 1, 0);
         chk("rw.std.level", 32'(lvl_s), 32'd3);
      end
      chk("rw.std.last_rdata", 32'(rd_s), 32'h50);

      // ---- FWFT latency and bubble-free reads ----
      step(0, 8'h00, 0, 1);
      step(1, 8'hA5, 0, 0);
      chk("fw.a5.empty_k", 32'(emp_f), 32'd1);
      step(0, 8'h00, 0, 0);
      chk("fw.a5.empty_k1", 32'(emp_f), 32'd0);
      chk("fw.a5.rdata_k1", 32'(rd_f), 32'hA5);
      step(1, 8'hB1, 0, 0);
      step(1, 8'hB2, 0, 0);
      for (int i = 0; i < 6; i++) begin
         step(1, 8'h30 + 8'(i), 1, 0);
         chk("fw.b2b.empty", 32'(emp_f), 32'd0);
      end
      chk("fw.b2b.rdata", 32'(rd_f), 32'h33);

      // ---- thresholds follow combinationally ----
      step(0, 8'h00, 0, 1);
      af_level = 4'd6; ae_level = 4'd1;
      for (int i = 0; i < 4; i++) step(1, 8'h50 + 8'(i), 0, 0);
      chk("thr.afull_before", 32'(af_s), 32'd0);
      af_level = 4'd3;
      #1;
      chk("thr.afull_same_cycle", 32'(af_s), 32'd1);
      ae_level = 4'd8;
      #1;
      chk("thr.aempty_ge_depth", 32'(ae_f), 32'd1);
      af_level = 4'd0;
      #1;
      compare_all();
      af_level = 4'd6; ae_level = 4'd1;

      // ---- underflow sticky, flush beats write ----
      step(0, 8'h00, 0, 1);
      step(0, 8'h00, 1, 0);
      step(0, 8'h00, 0, 0);
      chk("unf.sticky", 32'(un_s), 32'd1);
      step(1, 8'hEE, 0, 1);
      chk("flush.level", 32'(lvl_s), 32'd0);
      chk("flush.unf",   32'(un_f), 32'd0);
      step(0, 8'h00, 0, 0);
      chk("flush.dropped", 32'(emp_f), 32'd1);

      // ---- randomized traffic with alternating fill/drain bias ----
      for (int i = 0; i < 400; i++) begin
         wp = ((i / 50) % 2 == 0) ? 80 : 25;
         if ($urandom_range(0, 19) == 0) begin
            af_level = 4'($urandom_range(0, 9));
            ae_level = 4'($urandom_range(0, 9));
         end
         step($urandom_range(0, 99) < wp, 8'($urandom),
              $urandom_range(0, 99) < (100 - wp), $urandom_range(0, 39) == 0);
      end

      // ---- asynchronous reset in the middle of a burst ----
      for (int i = 0; i < 5; i++) step(1, 8'h60 + 8'(i), i > 2, 0);
      #2 reset = 1'b0;
      #1;
      model_reset();
      compare_all();
      chk("arst.fw.level", 32'(lvl_f), 32'd0);
      @(negedge clk) reset = 1'b1;
      step(1, 8'h77, 0, 0);
      step(0, 8'h00, 0, 0);
      chk("arst.fw.newdata", 32'(rd_f), 32'h77);
      step(0, 8'h00, 1, 0);
      chk("arst.std.newdata", 32'(rd_s), 32'h77);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/fifo_sync_prog.md
Name: fifo_sync_prog

Overview:
Parametrised single-clock FIFO, successor to the team's simple dual-port-RAM FIFO.
- Two read modes: standard (registered read) and first-word-fall-through (FWFT).
- Run-time programmable almost-full/almost-empty thresholds, fill-level output, synchronous flush, sticky overflow/underflow error flags.
- Correct occupancy accounting on simultaneous read and write.
- Sits between streaming producers and consumers in the same clock domain.

Parameters:
DATA_WIDTH, 8, width of each stored word
DEPTH, 256, number of entries; must be a power of two, at least 4
FWFT, 0, 0 = standard read mode, 1 = first-word-fall-through mode
AW, $clog2(DEPTH), local, address width; level/threshold width is AW+1

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
flush  in  1  synchronous clear of contents
write  in  1  write request
write_data  in  DATA_WIDTH  word to store
read  in  1  read request (in FWFT mode: acknowledge of the head word)
read_data  out  DATA_WIDTH  output word
af_level  in  AW+1  almost-full threshold
ae_level  in  AW+1  almost-empty threshold
level  out  AW+1  words currently held, 0..DEPTH
empty  out  1  no word available to read
full  out  1  level == DEPTH
almost_full  out  1  level >= af_level
almost_empty  out  1  level <= ae_level
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (reset=0, takes effect asynchronously):
  - Pointers, level, output-valid, overflow, underflow and read_data all go to 0.
  - Outputs after reset: empty=1, full=0, almost_empty=1, almost_full=(af_level==0).
- Storage: internal array with synchronous read. Pointers are AW bits and wrap DEPTH-1 → 0.
- Acceptance:
  - Write is accepted when write & !full. Full is never bypassed, even if read is asserted in the same cycle.
  - Read is accepted when read & !empty.
  - A rejected write sets overflow. A rejected read sets underflow. Contents and pointers are unchanged in either case.
- level update:
  - Accepted write only: +1.
  - Accepted read only: −1.
  - Both in the same cycle: unchanged.
  - level is a registered value; full, almost_full and almost_empty are combinational from level and the threshold ports.
- Standard mode (FWFT=0):
  - empty = (level == 0).
  - Accepted read at edge k: read_data holds the head word after edge k. read_data holds its value at all other times.
  - A word written at edge k is readable (empty=0) after edge k.
- FWFT mode (FWFT=1):
  - An output register holds the head word plus an out_valid bit. empty = !out_valid. level counts the word in the output register.
  - When out_valid=0 and the array holds a word, prefetch it into the output register.
  - Write into an empty FIFO at edge k: read_data valid and empty=0 after edge k+1.
  - Accepted read at edge k while the array is non-empty: the next word is on read_data after edge k, with no bubble.
  - Accepted read while the array is empty: out_valid clears. If a write is accepted in the same cycle, that word appears after edge k+1.
- flush=1 at an edge:
  - Clears pointers, level and out_valid; empty=1 after the edge.
  - Takes priority over write/read in the same cycle; those requests are dropped and no flag is set.
  - Also clears overflow and underflow.
  - read_data keeps its last value.
- Thresholds: may change at any time; flags follow combinationally.
  - af_level=0 → almost_full is always 1.
  - ae_level >= DEPTH → almost_empty is always 1.
- Wrap-around: full and empty must be correct across arbitrarily many pointer wraps.

Test Plan:
- DEPTH=8, FWFT=0: write 8 words 0x10..0x17 → full=1 and level=8 after the 8th edge. A 9th write → overflow=1, level stays 8. Read 8 → data 0x10..0x17 in order, then empty=1.
- Simultaneous read+write at level=3, held for 20 cycles → level stays 3, pointers wrap at least twice, data order preserved.
- FWFT=1, empty FIFO: write 0xA5 at edge k → empty=0 and read_data=0xA5 after edge k+1. Read with continuous back-to-back writes → one word per cycle, no bubbles.
- af_level=6, ae_level=1, DEPTH=8: fill 0→8 → almost_empty=1 at levels 0–1, almost_full=1 at levels ≥6. Change af_level to 3 at level 4 → almost_full=1 in the same cycle.
- Read while empty → underflow=1 and sticky. Assert flush together with write → level=0, empty=1, underflow=0, written word dropped.
- Assert reset (0) asynchronously mid-burst with FWFT=1 → all outputs at reset values immediately. After release, the first write/read pair returns the new data only.
